// File: rtl/gpio_pkg.sv
// Shared constants for the GPIO input conditioner: LED mode encoding and width.
package gpio_pkg;
  localparam int MODE_W = 2;

  localparam logic [MODE_W-1:0] MODE_PASS   = 2'd0;
  localparam logic [MODE_W-1:0] MODE_TOGGLE = 2'd1;
  localparam logic [MODE_W-1:0] MODE_INVERT = 2'd2;
  localparam logic [MODE_W-1:0] MODE_SHIFT  = 2'd3;
endpackage

// File: rtl/gpio_in_conditioner_if.sv
// Button/LED bundle between the board-side driver and the input conditioner.
interface gpio_in_conditioner_if
  import gpio_pkg::*;
#(
  parameter int CHANNELS = 3
);
  logic [CHANNELS-1:0] btn_in;
  logic [MODE_W-1:0]   mode;
  logic [CHANNELS-1:0] led_out;
  logic [CHANNELS-1:0] btn_level;
  logic [CHANNELS-1:0] rise_pulse;
  logic [CHANNELS-1:0] fall_pulse;

  modport master (
    output btn_in, mode,
    input  led_out, btn_level, rise_pulse, fall_pulse
  );

  modport slave (
    input  btn_in, mode,
    output led_out, btn_level, rise_pulse, fall_pulse
  );
endinterface

// File: rtl/gpio_debounce.sv
// One button channel: 2-flop synchroniser, stability counter, debounced level
// and registered rise/fall pulses. level_next is exported for the LED logic.
module gpio_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic level,
  output logic level_next,
  output logic rise,
  output logic fall
);
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;

  // A new level is only accepted after s2 has disagreed for DEBOUNCE_CYCLES edges.
  always_comb begin
    level_next = level;
    cnt_next   = cnt + 1'b1;
    if (s2 == level) begin
      cnt_next = '0;
    end else if (cnt == CNT_MAX) begin
      level_next = s2;
      cnt_next   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      s1    <= btn_in;
      s2    <= s1;
      cnt   <= cnt_next;
      level <= level_next;
      rise  <= level_next & ~level;
      fall  <= ~level_next & level;
    end
  end
endmodule

// File: rtl/gpio_in_conditioner.sv
// Per-channel debounce followed by the registered LED drive in one of four
// run-time modes (pass, toggle, invert, shift).
module gpio_in_conditioner
  import gpio_pkg::*;
#(
  parameter int CHANNELS        = 3,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  gpio_in_conditioner_if.slave  io
);
  logic [CHANNELS-1:0] level;
  logic [CHANNELS-1:0] level_next;
  logic [CHANNELS-1:0] rise;
  logic [CHANNELS-1:0] fall;
  logic [CHANNELS-1:0] rise_next;
  logic [CHANNELS-1:0] led;
  logic [CHANNELS-1:0] led_next;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    gpio_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_deb (
      .clk        (clk),
      .rst        (rst),
      .btn_in     (io.btn_in[i]),
      .level      (level[i]),
      .level_next (level_next[i]),
      .rise       (rise[i]),
      .fall       (fall[i])
    );
  end

  // Same-edge view of the rise pulse so led_out changes together with rise_pulse.
  assign rise_next = level_next & ~level;

  always_comb begin
    led_next = led;
    case (io.mode)
      MODE_PASS:   led_next = level_next;
      MODE_INVERT: led_next = ~level_next;
      MODE_TOGGLE: led_next = led ^ rise_next;
      MODE_SHIFT: begin
        if (rise_next[0]) led_next = {led[CHANNELS-2:0], level[1]};
      end
      default:     led_next = led;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) led <= '0;
    else     led <= led_next;
  end

  assign io.led_out    = led;
  assign io.btn_level  = level;
  assign io.rise_pulse = rise;
  assign io.fall_pulse = fall;
endmodule

// File: tb/tb_gpio_in_conditioner.sv
// Directed bench for gpio_in_conditioner with CHANNELS=3, DEBOUNCE_CYCLES=4.
module tb_gpio_in_conditioner;
  import gpio_pkg::*;

  localparam int CH = 3;

  logic clk;
  logic rst;
  int   tests;
  int   failed;

  gpio_in_conditioner_if #(.CHANNELS(CH)) bus ();

  gpio_in_conditioner #(
    .CHANNELS        (CH),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] btn;
    logic [1:0] mode;
    int         cycles;
    logic [2:0] exp_led;
    logic [2:0] exp_level;
    logic [2:0] exp_rise;
    logic [2:0] exp_fall;
  } vec_t;

  vec_t vec [14];

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_all(input string name, input logic [2:0] led, input logic [2:0] lvl,
                           input logic [2:0] rise, input logic [2:0] fall);
    check({name, " led"},   bus.led_out,    led);
    check({name, " level"}, bus.btn_level,  lvl);
    check({name, " rise"},  bus.rise_pulse, rise);
    check({name, " fall"},  bus.fall_pulse, fall);
  endtask

  task automatic drive(input logic [2:0] btn, input logic [1:0] mode);
    bus.btn_in = btn;
    bus.mode   = mode;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  initial begin
    tests  = 0;
    failed = 0;

    // PASS / glitch / TOGGLE / mode changes / INVERT, continuing from test 1
    vec[0]  = '{3'b000, MODE_PASS,   5, 3'b001, 3'b001, 3'b000, 3'b000};
    vec[1]  = '{3'b000, MODE_PASS,   1, 3'b000, 3'b000, 3'b000, 3'b001};
    vec[2]  = '{3'b001, MODE_PASS,   3, 3'b000, 3'b000, 3'b000, 3'b000};
    vec[3]  = '{3'b000, MODE_PASS,   8, 3'b000, 3'b000, 3'b000, 3'b000};
    vec[4]  = '{3'b100, MODE_TOGGLE, 5, 3'b000, 3'b000, 3'b000, 3'b000};
    vec[5]  = '{3'b100, MODE_TOGGLE, 1, 3'b100, 3'b100, 3'b100, 3'b000};
    vec[6]  = '{3'b000, MODE_TOGGLE, 6, 3'b100, 3'b000, 3'b000, 3'b100};
    vec[7]  = '{3'b100, MODE_TOGGLE, 6, 3'b000, 3'b100, 3'b100, 3'b000};
    vec[8]  = '{3'b000, MODE_TOGGLE, 6, 3'b000, 3'b000, 3'b000, 3'b100};
    vec[9]  = '{3'b011, MODE_TOGGLE, 6, 3'b011, 3'b011, 3'b011, 3'b000};
    vec[10] = '{3'b000, MODE_TOGGLE, 6, 3'b011, 3'b000, 3'b000, 3'b011};
    vec[11] = '{3'b000, MODE_INVERT, 1, 3'b111, 3'b000, 3'b000, 3'b000};
    vec[12] = '{3'b010, MODE_INVERT, 6, 3'b101, 3'b010, 3'b010, 3'b000};
    vec[13] = '{3'b010, MODE_PASS,   1, 3'b010, 3'b010, 3'b000, 3'b000};

    rst = 1'b1;
    drive(3'b000, MODE_PASS);
    step(2);
    check_all("reset", 3'b000, 3'b000, 3'b000, 3'b000);
    rst = 1'b0;

    // Test 1: clean press on ch0 in PASS, six-edge latency, one-cycle rise pulse
    drive(3'b001, MODE_PASS);
    step(5);
    check_all("t1 pre", 3'b000, 3'b000, 3'b000, 3'b000);
    step(1);
    check_all("t1 edge6", 3'b001, 3'b001, 3'b001, 3'b000);
    step(1);
    check_all("t1 edge7", 3'b001, 3'b001, 3'b000, 3'b000);

    for (int i = 0; i < 14; i++) begin
      drive(vec[i].btn, vec[i].mode);
      step(vec[i].cycles);
      check_all($sformatf("vec%0d", i), vec[i].exp_led, vec[i].exp_level,
                vec[i].exp_rise, vec[i].exp_fall);
    end

    // Test 4: SHIFT with ch0 as clock and ch1 as data
    pulse_reset();
    drive(3'b010, MODE_SHIFT);
    step(6);
    check("shift data only", bus.led_out, 3'b000);
    drive(3'b011, MODE_SHIFT);
    step(6);
    check("shift 1", bus.led_out, 3'b001);
    drive(3'b000, MODE_SHIFT);
    step(6);
    check("shift release", bus.led_out, 3'b001);
    drive(3'b001, MODE_SHIFT);
    step(6);
    check("shift 2", bus.led_out, 3'b010);
    drive(3'b000, MODE_SHIFT);
    step(6);
    drive(3'b010, MODE_SHIFT);
    step(6);
    drive(3'b011, MODE_SHIFT);
    step(6);
    check("shift 3", bus.led_out, 3'b101);

    // Test 5: asynchronous reset in the middle of a count
    drive(3'b010, MODE_PASS);
    step(6);
    check("t5 setup", bus.led_out, 3'b010);
    drive(3'b011, MODE_PASS);
    step(4);
    rst = 1'b1;
    #1;
    check_all("t5 async", 3'b000, 3'b000, 3'b000, 3'b000);
    step(1);
    rst = 1'b0;
    step(5);
    check_all("t5 pre", 3'b000, 3'b000, 3'b000, 3'b000);
    step(1);
    check_all("t5 edge6", 3'b011, 3'b011, 3'b011, 3'b000);
    step(1);
    check_all("t5 edge7", 3'b011, 3'b011, 3'b000, 3'b000);

    // Test 6: INVERT straight out of reset
    drive(3'b000, MODE_INVERT);
    rst = 1'b1;
    step(1);
    check("t6 in reset", bus.led_out, 3'b000);
    rst = 1'b0;
    step(1);
    check("t6 first edge", bus.led_out, 3'b111);
    drive(3'b010, MODE_INVERT);
    step(5);
    check("t6 pre", bus.led_out, 3'b111);
    step(1);
    check("t6 press", bus.led_out, 3'b101);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
